// File: rtl/instr_mem_loadable.sv
// Instruction memory with a registered fetch port and a byte-serial big-endian program loader.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_mem_loadable #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic [DATA_W-1:0]          instr,
  output logic                       instr_valid,
  output logic                       addr_fault,
  output logic                       fetch_stall,
  input  logic                       load_start,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic [7:0]                 load_byte,
  input  logic                       load_byte_valid,
  output logic                       load_done,
  output logic                       load_err
`ifdef IMEM_PARITY_EN
  , output logic                     parity_err
`endif
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned LEN_W  = IDX_W + 1;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_n;
  logic [LEN_W-1:0]    ptr, ptr_n, len_q, len_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic [DATA_W-1:0]   asm_q, asm_n, asm_shift;
  logic                err_n;
  logic                wr_en;

  // Contents survive reset; they start as NOP_WORD at time zero
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: NOP_WORD};
`ifdef IMEM_PARITY_EN
  logic                mem_par [DEPTH] = '{default: ^NOP_WORD};
`endif

  assign asm_shift = DATA_W'({asm_q, load_byte});

  // Loader next-state logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    bcnt_n  = bcnt;
    asm_n   = asm_q;
    len_n   = len_q;
    err_n   = load_err;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (load_len != '0 && load_len <= LEN_W'(DEPTH)) begin
            state_n = LOAD;
            ptr_n   = '0;
            bcnt_n  = '0;
            len_n   = load_len;
            err_n   = 1'b0;
          end else begin
            err_n   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_byte_valid) begin
          asm_n = asm_shift;
          if (bcnt == BCNT_W'(BYTES - 1)) begin
            wr_en  = 1'b1;
            bcnt_n = '0;
            ptr_n  = ptr + LEN_W'(1);
            if (ptr + LEN_W'(1) == len_q) state_n = DONE;
          end else begin
            bcnt_n = bcnt + BCNT_W'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      bcnt        <= '0;
      asm_q       <= '0;
      len_q       <= '0;
      load_err    <= 1'b0;
      load_done   <= 1'b0;
      fetch_stall <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      bcnt        <= bcnt_n;
      asm_q       <= asm_n;
      len_q       <= len_n;
      load_err    <= err_n;
      load_done   <= (state_n == DONE);
      fetch_stall <= (state_n != IDLE);
    end
  end

  // Write port: the completed word lands on the edge that takes its last byte
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr[IDX_W-1:0]] <= asm_shift;
`ifdef IMEM_PARITY_EN
      mem_par[ptr[IDX_W-1:0]] <= ^asm_shift;
`endif
    end
  end

  logic [ADDR_W-1:0] word_idx;
  logic              accept, fault;

  assign word_idx = fetch_addr / ADDR_W'(BYTES);
  assign accept   = fetch_req && !fetch_stall;
  assign fault    = ((fetch_addr % ADDR_W'(BYTES)) != '0) || (word_idx >= ADDR_W'(DEPTH));

  // Fetch port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
`ifdef IMEM_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      instr_valid <= accept;
      if (accept) begin
        if (fault) begin
          instr      <= NOP_WORD;
          addr_fault <= 1'b1;
`ifdef IMEM_PARITY_EN
          parity_err <= 1'b0;
`endif
        end else begin
          instr      <= mem[word_idx[IDX_W-1:0]];
          addr_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
          parity_err <= (^mem[word_idx[IDX_W-1:0]]) != mem_par[word_idx[IDX_W-1:0]];
`endif
        end
      end
    end
  end

endmodule
